rprelu_stream: RTL and testbench

RPRELU_STREAM -- requirements
Module: rprelu_stream

---
 rtl/rprelu_stream.sv | 162 ++++++++++++++++
 tb/tb_rprelu_stream.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rprelu_stream.sv
// RPReLU activation over a lane-parallel channel stream: per-channel beta/gamma/zeta
// register file, three-stage arithmetic pipeline, bypass mode and valid/ready backpressure.
module rprelu_stream #(
    parameter int DATA_WIDTH  = 16,
    parameter int PARA_WIDTH  = 16,
    parameter int CHANNEL_NUM = 128,
    parameter int LANES       = 16,
    parameter int FRAC_BITS   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           mode,
    input  logic                           clr,
    input  logic                           prm_wr,
    input  logic [$clog2(CHANNEL_NUM)-1:0] prm_addr,
    input  logic signed [PARA_WIDTH-1:0]   prm_beta,
    input  logic signed [PARA_WIDTH-1:0]   prm_gamma,
    input  logic signed [PARA_WIDTH-1:0]   prm_zeta,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]    in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*DATA_WIDTH-1:0]    out_data,
    output logic                           out_last
);
    localparam int ADDR_W = $clog2(CHANNEL_NUM);
    localparam int GROUPS = CHANNEL_NUM / LANES;
    localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int DIFF_W = ((DATA_WIDTH > PARA_WIDTH) ? DATA_WIDTH : PARA_WIDTH) + 1;
    localparam int PROD_W = PARA_WIDTH + DIFF_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [PARA_WIDTH-1:0] beta_mem  [CHANNEL_NUM];
    logic signed [PARA_WIDTH-1:0] gamma_mem [CHANNEL_NUM];
    logic signed [PARA_WIDTH-1:0] zeta_mem  [CHANNEL_NUM];

    // NOTE: the coefficient file is reset because all-zero coefficients define the idle ReLU behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNEL_NUM; i++) begin
                beta_mem[i]  <= '0;
                gamma_mem[i] <= '0;
                zeta_mem[i]  <= '0;
            end
        end else if (prm_wr) begin
            beta_mem[prm_addr]  <= prm_beta;
            gamma_mem[prm_addr] <= prm_gamma;
            zeta_mem[prm_addr]  <= prm_zeta;
        end
    end

    logic             stall;
    logic             accept;
    logic [GRP_W-1:0] grp;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            grp <= '0;
        end else if (accept) begin
            grp <= (grp == GRP_W'(GROUPS-1)) ? '0 : grp + 1'b1;
        end
    end

    // Lane unpack and coefficient lookup; the register file is read before this edge's write lands.
    logic signed [DATA_WIDTH-1:0] in_x      [LANES];
    logic signed [PARA_WIDTH-1:0] sel_beta  [LANES];
    logic signed [PARA_WIDTH-1:0] sel_gamma [LANES];
    logic signed [PARA_WIDTH-1:0] sel_zeta  [LANES];
    logic signed [DIFF_W-1:0]     diff_c    [LANES];

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            in_x[k]      = $signed(in_data[k*DATA_WIDTH +: DATA_WIDTH]);
            sel_beta[k]  = beta_mem[ADDR_W'(int'(grp) * LANES + k)];
            sel_gamma[k] = gamma_mem[ADDR_W'(int'(grp) * LANES + k)];
            sel_zeta[k]  = zeta_mem[ADDR_W'(int'(grp) * LANES + k)];
            diff_c[k]    = DIFF_W'(in_x[k]) - DIFF_W'(sel_gamma[k]);
        end
    end

    logic                         s1_valid, s1_mode, s1_last;
    logic signed [DATA_WIDTH-1:0] s1_x    [LANES];
    logic signed [DIFF_W-1:0]     s1_diff [LANES];
    logic                         s1_pos  [LANES];
    logic signed [PARA_WIDTH-1:0] s1_beta [LANES];
    logic signed [PARA_WIDTH-1:0] s1_zeta [LANES];

    logic                         s2_valid, s2_mode, s2_last;
    logic signed [DATA_WIDTH-1:0] s2_x    [LANES];
    logic signed [DIFF_W-1:0]     s2_diff [LANES];
    logic                         s2_pos  [LANES];
    logic signed [PARA_WIDTH-1:0] s2_zeta [LANES];
    logic signed [PROD_W-1:0]     s2_prod [LANES];

    // Stage 3 arithmetic: floor shift, zeta offset, saturation, bypass select.
    logic signed [PROD_W-1:0]     shifted [LANES];
    logic signed [SUM_W-1:0]      sum_c   [LANES];
    logic [LANES*DATA_WIDTH-1:0]  y_packed;

    always_comb begin
        y_packed = '0;
        for (int k = 0; k < LANES; k++) begin
            shifted[k] = s2_prod[k] >>> FRAC_BITS;
            sum_c[k]   = (s2_pos[k] ? SUM_W'(s2_diff[k]) : SUM_W'(shifted[k])) + SUM_W'(s2_zeta[k]);
            if (s2_mode) begin
                y_packed[k*DATA_WIDTH +: DATA_WIDTH] = s2_x[k];
            end else if (sum_c[k] > SAT_MAX) begin
                y_packed[k*DATA_WIDTH +: DATA_WIDTH] = SAT_MAX[DATA_WIDTH-1:0];
            end else if (sum_c[k] < SAT_MIN) begin
                y_packed[k*DATA_WIDTH +: DATA_WIDTH] = SAT_MIN[DATA_WIDTH-1:0];
            end else begin
                y_packed[k*DATA_WIDTH +: DATA_WIDTH] = sum_c[k][DATA_WIDTH-1:0];
            end
        end
    end

    // NOTE: only valids and the visible outputs are reset; datapath registers are qualified by their valids.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (!stall) begin
            s1_valid  <= accept;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            out_last  <= s2_valid & s2_last;
            out_data  <= y_packed;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_mode <= mode;
            s1_last <= (grp == GRP_W'(GROUPS-1));
            s2_mode <= s1_mode;
            s2_last <= s1_last;
            for (int k = 0; k < LANES; k++) begin
                s1_x[k]    <= in_x[k];
                s1_diff[k] <= diff_c[k];
                s1_pos[k]  <= !diff_c[k][DIFF_W-1] && (diff_c[k] != '0);
                s1_beta[k] <= sel_beta[k];
                s1_zeta[k] <= sel_zeta[k];
                s2_x[k]    <= s1_x[k];
                s2_diff[k] <= s1_diff[k];
                s2_pos[k]  <= s1_pos[k];
                s2_zeta[k] <= s1_zeta[k];
                s2_prod[k] <= PROD_W'(s1_beta[k]) * PROD_W'(s1_diff[k]);
            end
        end
    end

endmodule

// File: tb/tb_rprelu_stream.sv
// Self-checking bench for rprelu_stream: directed corner cases plus randomized traffic
// scored against a plain-arithmetic model of the activation, group counter and reset.
module tb_rprelu_stream;
    localparam int DW     = 16;
    localparam int PW     = 16;
    localparam int CN     = 128;
    localparam int L      = 16;
    localparam int FB     = 8;
    localparam int GROUPS = CN / L;
    localparam int BW     = L * DW;

    logic                 clk = 1'b0;
    logic                 rst, mode, clr, prm_wr;
    logic [6:0]           prm_addr;
    logic signed [PW-1:0] prm_beta, prm_gamma, prm_zeta;
    logic                 in_valid, in_ready, out_valid, out_ready, out_last;
    logic [BW-1:0]        in_data, out_data;

    always #5 clk = ~clk;

    rprelu_stream #(
        .DATA_WIDTH(DW), .PARA_WIDTH(PW), .CHANNEL_NUM(CN), .LANES(L), .FRAC_BITS(FB)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .clr(clr), .prm_wr(prm_wr), .prm_addr(prm_addr),
        .prm_beta(prm_beta), .prm_gamma(prm_gamma), .prm_zeta(prm_zeta),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    typedef struct {
        logic [BW-1:0] data;
        logic          last;
        int            edge_n;
        bit            valid;
    } beat_t;

    beat_t exp_q[$];     // accepted, not yet emitted
    beat_t exp_done[$];  // expectation paired with each emitted beat
    beat_t got_q[$];     // emitted beats
    int    m_beta[CN], m_gamma[CN], m_zeta[CN];
    int    m_grp;
    int    edge_n;
    int    vectors;
    int    miscompares;

    function automatic int ref_y(int x, int b, int g, int z);
        longint d, p, q, y, den;
        den = longint'(1) << FB;
        d   = longint'(x) - longint'(g);
        if (x > g) begin
            y = d + longint'(z);
        end else begin
            p = longint'(b) * d;
            q = p / den;
            if (p < 0 && (p % den) != 0) q = q - 1;
            y = q + longint'(z);
        end
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return int'(y);
    endfunction

    function automatic logic [BW-1:0] ref_beat(logic [BW-1:0] x_in, bit md, int grp);
        logic [BW-1:0]        r;
        logic signed [DW-1:0] xl;
        int                   y;
        r = x_in;
        if (!md) begin
            for (int k = 0; k < L; k++) begin
                xl = x_in[k*DW +: DW];
                y  = ref_y(int'(xl), m_beta[grp*L+k], m_gamma[grp*L+k], m_zeta[grp*L+k]);
                r[k*DW +: DW] = y[DW-1:0];
            end
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] rand_data();
        logic [BW-1:0] r;
        for (int w = 0; w < BW/32; w++) r[w*32 +: 32] = $urandom();
        return r;
    endfunction

    // One clock: record handshakes seen on the coming edge and advance the model.
    task automatic step();
        bit acc, fire;
        #1;
        acc  = (in_valid === 1'b1) && (in_ready === 1'b1) && (rst !== 1'b1);
        fire = (out_valid === 1'b1) && (out_ready === 1'b1) && (rst !== 1'b1);
        if (fire) begin
            got_q.push_back('{data: out_data, last: out_last, edge_n: edge_n + 1, valid: 1'b1});
            if (exp_q.size() > 0) exp_done.push_back(exp_q.pop_front());
            else exp_done.push_back('{data: '0, last: 1'b0, edge_n: 0, valid: 1'b0});
        end
        if (rst === 1'b1) begin
            for (int i = 0; i < CN; i++) begin
                m_beta[i] = 0; m_gamma[i] = 0; m_zeta[i] = 0;
            end
            m_grp = 0;
            exp_q.delete();
        end else begin
            if (acc) exp_q.push_back('{data: ref_beat(in_data, mode, m_grp),
                                      last: (m_grp == GROUPS-1), edge_n: edge_n + 1, valid: 1'b1});
            if (prm_wr === 1'b1) begin
                m_beta[prm_addr]  = int'(prm_beta);
                m_gamma[prm_addr] = int'(prm_gamma);
                m_zeta[prm_addr]  = int'(prm_zeta);
            end
            if (clr === 1'b1) m_grp = 0;
            else if (acc) m_grp = (m_grp + 1) % GROUPS;
        end
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    task automatic idle(int n);
        in_valid = 1'b0; clr = 1'b0; prm_wr = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write_prm(int ch, int b, int g, int z);
        prm_wr = 1'b1; prm_addr = 7'(ch);
        prm_beta = PW'(b); prm_gamma = PW'(g); prm_zeta = PW'(z);
        step();
        prm_wr = 1'b0;
    endtask

    task automatic send(logic [BW-1:0] d, bit md);
        in_valid = 1'b1; in_data = d; mode = md;
        step();
        in_valid = 1'b0; mode = 1'b0;
    endtask

    task automatic group_clear();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; clr = 1'b0; prm_wr = 1'b0; prm_addr = '0;
        prm_beta = '0; prm_gamma = '0; prm_zeta = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        step(); step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
        vectors++;
        if (out_last !== 1'b0) begin miscompares++; $display("FAIL rst_out_last: got %b, expected 0", out_last); end
        vectors++;
        if (out_data !== '0) begin miscompares++; $display("FAIL rst_out_data: got %h, expected 0", out_data); end
        rst = 1'b0;
        step();
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b, expected 1", in_ready); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_idle_valid: got %b, expected 0", out_valid); end
    endtask

    task automatic test_branches();
        logic [BW-1:0]        d;
        logic signed [DW-1:0] v;
        int                   xs[5]  = '{100, -256, -1, 32767, -32768};
        int                   dir[5] = '{85, -64, -1, 32767, -32768};
        group_clear();
        write_prm(0, 0, 20, 5);
        write_prm(1, 64, 0, 0);
        write_prm(2, 1, 0, 0);
        write_prm(3, 0, -32768, 0);
        write_prm(4, 256, 32767, -100);
        d = rand_data();
        for (int k = 0; k < 5; k++) d[k*DW +: DW] = DW'(xs[k]);
        send(d, 1'b0);
        idle(6);
        vectors++;
        if (got_q.size() != 1) begin
            miscompares++; $display("FAIL br_count: got %0d beats, expected 1", got_q.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                v = got_q[0].data[k*DW +: DW];
                vectors++;
                if (int'(v) != dir[k]) begin
                    miscompares++; $display("FAIL br_lane%0d: got %0d, expected %0d", k, v, dir[k]);
                end
            end
        end
        foreach (got_q[i]) begin
            vectors++;
            if (!exp_done[i].valid || got_q[i].data !== exp_done[i].data || got_q[i].last !== exp_done[i].last) begin
                miscompares++;
                $display("FAIL br_beat[%0d]: got %h/%b, expected %h/%b", i, got_q[i].data, got_q[i].last, exp_done[i].data, exp_done[i].last);
            end
        end
        got_q.delete(); exp_done.delete();
    endtask

    task automatic test_bypass_latency();
        logic [BW-1:0]        d;
        logic signed [DW-1:0] v;
        d = rand_data();
        d[0 +: DW] = DW'(-300);
        send(d, 1'b1);
        idle(6);
        vectors++;
        if (got_q.size() != 1) begin
            miscompares++; $display("FAIL byp_count: got %0d beats, expected 1", got_q.size());
        end else begin
            v = got_q[0].data[0 +: DW];
            vectors++;
            if (int'(v) != -300) begin miscompares++; $display("FAIL byp_lane0: got %0d, expected -300", v); end
            vectors++;
            if (got_q[0].data !== d) begin miscompares++; $display("FAIL byp_data: got %h, expected %h", got_q[0].data, d); end
            vectors++;
            if (got_q[0].edge_n - exp_done[0].edge_n != 3) begin
                miscompares++; $display("FAIL byp_latency: got %0d cycles, expected 3", got_q[0].edge_n - exp_done[0].edge_n);
            end
        end
        got_q.delete(); exp_done.delete();
    endtask

    task automatic test_hazard();
        logic [BW-1:0]        d;
        logic signed [DW-1:0] v;
        group_clear();
        write_prm(0, 0, 0, 0);
        d = rand_data();
        d[0 +: DW] = DW'(50);
        prm_wr = 1'b1; prm_addr = 7'd0; prm_beta = '0; prm_gamma = '0; prm_zeta = PW'(10);
        send(d, 1'b0);
        prm_wr = 1'b0;
        for (int i = 0; i < GROUPS-1; i++) send(rand_data(), 1'b0);
        send(d, 1'b0);
        idle(6);
        vectors++;
        if (got_q.size() != GROUPS+1) begin
            miscompares++; $display("FAIL hz_count: got %0d beats, expected %0d", got_q.size(), GROUPS+1);
        end else begin
            v = got_q[0].data[0 +: DW];
            vectors++;
            if (int'(v) != 50) begin miscompares++; $display("FAIL hz_old_value: got %0d, expected 50", v); end
            v = got_q[GROUPS].data[0 +: DW];
            vectors++;
            if (int'(v) != 60) begin miscompares++; $display("FAIL hz_new_value: got %0d, expected 60", v); end
        end
        foreach (got_q[i]) begin
            vectors++;
            if (!exp_done[i].valid || got_q[i].data !== exp_done[i].data || got_q[i].last !== exp_done[i].last) begin
                miscompares++;
                $display("FAIL hz_beat[%0d]: got %h/%b, expected %h/%b", i, got_q[i].data, got_q[i].last, exp_done[i].data, exp_done[i].last);
            end
        end
        got_q.delete(); exp_done.delete();
    endtask

    task automatic test_last_wrap();
        group_clear();
        for (int i = 0; i < 16; i++) send(rand_data(), 1'b0);
        idle(6);
        vectors++;
        if (got_q.size() != 16) begin miscompares++; $display("FAIL wrap_count: got %0d beats, expected 16", got_q.size()); end
        foreach (got_q[i]) begin
            vectors++;
            if (got_q[i].last !== ((i == 7 || i == 15) ? 1'b1 : 1'b0)) begin
                miscompares++; $display("FAIL wrap_last[%0d]: got %b, expected %b", i, got_q[i].last, (i == 7 || i == 15));
            end
        end
        got_q.delete(); exp_done.delete();
        for (int i = 0; i < 3; i++) send(rand_data(), 1'b0);
        group_clear();
        for (int i = 0; i < 8; i++) send(rand_data(), 1'b0);
        idle(6);
        vectors++;
        if (got_q.size() != 11) begin miscompares++; $display("FAIL clr_count: got %0d beats, expected 11", got_q.size()); end
        foreach (got_q[i]) begin
            vectors++;
            if (got_q[i].last !== ((i == 10) ? 1'b1 : 1'b0) || !exp_done[i].valid || got_q[i].data !== exp_done[i].data) begin
                miscompares++; $display("FAIL clr_beat[%0d]: got last=%b data=%h, expected last=%b data=%h", i, got_q[i].last, got_q[i].data, (i == 10), exp_done[i].data);
            end
        end
        got_q.delete(); exp_done.delete();
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] held;
        out_ready = 1'b1; mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = rand_data();
            step();
        end
        held = out_data;
        in_data = rand_data();
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b0; in_valid = 1'b1;
            #1;
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
                miscompares++;
                $display("FAIL bp_stall[%0d]: got in_ready=%b out_valid=%b data=%h, expected 0 1 %h", i, in_ready, out_valid, out_data, held);
            end
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            step();
            in_data = rand_data();
        end
        idle(6);
        vectors++;
        if (got_q.size() != 12) begin
            miscompares++; $display("FAIL bp_count: got %0d beats, expected 12", got_q.size());
        end else begin
            vectors++;
            if (got_q[1].data !== held) begin miscompares++; $display("FAIL bp_held_beat: got %h, expected %h", got_q[1].data, held); end
        end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL bp_dropped: got %0d beats missing, expected 0", exp_q.size()); end
        foreach (got_q[i]) begin
            vectors++;
            if (!exp_done[i].valid || got_q[i].data !== exp_done[i].data || got_q[i].last !== exp_done[i].last) begin
                miscompares++;
                $display("FAIL bp_beat[%0d]: got %h/%b, expected %h/%b", i, got_q[i].data, got_q[i].last, exp_done[i].data, exp_done[i].last);
            end
        end
        got_q.delete(); exp_done.delete();
    endtask

    task automatic test_random();
        for (int ch = 0; ch < CN; ch++)
            write_prm(ch, int'($urandom_range(0, 65535)) - 32768,
                      int'($urandom_range(0, 65535)) - 32768,
                      int'($urandom_range(0, 65535)) - 32768);
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            mode      = ($urandom_range(0, 9) == 0);
            clr       = ($urandom_range(0, 19) == 0);
            prm_wr    = ($urandom_range(0, 9) == 0);
            prm_addr  = 7'($urandom_range(0, CN-1));
            prm_beta  = PW'($urandom()); prm_gamma = PW'($urandom()); prm_zeta = PW'($urandom());
            in_data   = rand_data();
            step();
        end
        idle(8);
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL rnd_dropped: got %0d beats missing, expected 0", exp_q.size()); end
        foreach (got_q[i]) begin
            vectors++;
            if (!exp_done[i].valid || got_q[i].data !== exp_done[i].data || got_q[i].last !== exp_done[i].last) begin
                miscompares++;
                $display("FAIL rnd_beat[%0d]: got %h/%b, expected %h/%b", i, got_q[i].data, got_q[i].last, exp_done[i].data, exp_done[i].last);
            end
        end
        got_q.delete(); exp_done.delete();
    endtask

    task automatic test_reset_midstream();
        logic [BW-1:0]        d;
        logic signed [DW-1:0] v;
        out_ready = 1'b1;
        send(rand_data(), 1'b0);
        send(rand_data(), 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rm_in_ready: got %b, expected 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rm_flushed[%0d]: got out_valid=%b, expected 0", i, out_valid); end
        end
        d = rand_data();
        d[0 +: DW] = DW'(-5);
        d[DW +: DW] = DW'(7);
        send(d, 1'b0);
        idle(6);
        vectors++;
        if (got_q.size() != 1) begin
            miscompares++; $display("FAIL rm_count: got %0d beats, expected 1", got_q.size());
        end else begin
            v = got_q[0].data[0 +: DW];
            vectors++;
            if (int'(v) != 0) begin miscompares++; $display("FAIL rm_relu_neg: got %0d, expected 0", v); end
            v = got_q[0].data[DW +: DW];
            vectors++;
            if (int'(v) != 7) begin miscompares++; $display("FAIL rm_relu_pos: got %0d, expected 7", v); end
        end
        foreach (got_q[i]) begin
            vectors++;
            if (!exp_done[i].valid || got_q[i].data !== exp_done[i].data || got_q[i].last !== exp_done[i].last) begin
                miscompares++;
                $display("FAIL rm_beat[%0d]: got %h/%b, expected %h/%b", i, got_q[i].data, got_q[i].last, exp_done[i].data, exp_done[i].last);
            end
        end
        got_q.delete(); exp_done.delete();
    endtask

    initial begin
        vectors = 0; miscompares = 0; edge_n = 0; m_grp = 0;
        for (int i = 0; i < CN; i++) begin
            m_beta[i] = 0; m_gamma[i] = 0; m_zeta[i] = 0;
        end
        test_reset();
        test_branches();
        test_bypass_latency();
        test_hazard();
        test_last_wrap();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
